control_unit: RTL and testbench

Control sequencer for the RISC-SPM datapath. It reads the instruction word held by the instruction register and the zero-flag register, and steps a fetch/decode/execute state machine. Each cycle it drives every datapath load, increment, mux-select and memory-write strobe. It is the only consumer of the IR contents and the only block that drives the IR `load` strobe.

---
 rtl/control_unit_if.sv | 60 ++++++
 rtl/control_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Strobe/status bundle between the RISC-SPM control sequencer and its datapath.
// The controller side takes the master modport; the datapath (or a bench) takes slave.
interface control_unit_if #(
   parameter int WS = 8
);
   logic [WS-1:0] instruction;
   logic          zero;
   logic          load_r0;
   logic          load_r1;
   logic          load_r2;
   logic          load_r3;
   logic          load_pc;
   logic          inc_pc;
   logic [2:0]    sel_bus_1_mux;
   logic [1:0]    sel_bus_2_mux;
   logic          load_ir;
   logic          load_add_r;
   logic          load_reg_y;
   logic          load_reg_z;
   logic          write;
   logic          halted;

   modport master (
      input  instruction,
      input  zero,
      output load_r0,
      output load_r1,
      output load_r2,
      output load_r3,
      output load_pc,
      output inc_pc,
      output sel_bus_1_mux,
      output sel_bus_2_mux,
      output load_ir,
      output load_add_r,
      output load_reg_y,
      output load_reg_z,
      output write,
      output halted
   );

   modport slave (
      output instruction,
      output zero,
      input  load_r0,
      input  load_r1,
      input  load_r2,
      input  load_r3,
      input  load_pc,
      input  inc_pc,
      input  sel_bus_1_mux,
      input  sel_bus_2_mux,
      input  load_ir,
      input  load_add_r,
      input  load_reg_y,
      input  load_reg_z,
      input  write,
      input  halted
   );
endinterface

// File: rtl/control_unit.sv
// RISC-SPM control sequencer: fetch/decode/execute FSM driving every datapath strobe.
// Outputs are purely combinational from the state register, the IR word and the zero flag.
module control_unit #(
   parameter int ws = 8
) (
   input  logic           clk,
   input  logic           rst,
   control_unit_if.master bus
);
   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_FET1 = 4'd1,
      S_FET2 = 4'd2,
      S_DEC  = 4'd3,
      S_EX1  = 4'd4,
      S_RD1  = 4'd5,
      S_RD2  = 4'd6,
      S_WR1  = 4'd7,
      S_WR2  = 4'd8,
      S_BR1  = 4'd9,
      S_BR2  = 4'd10,
      S_HALT = 4'd11
   } state_t;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_RD  = 4'd5;
   localparam logic [3:0] OP_WR  = 4'd6;
   localparam logic [3:0] OP_BR  = 4'd7;
   localparam logic [3:0] OP_BRZ = 4'd8;

   localparam logic [2:0] SEL1_PC   = 3'd4;
   localparam logic [1:0] SEL2_ALU  = 2'd0;
   localparam logic [1:0] SEL2_BUS1 = 2'd1;
   localparam logic [1:0] SEL2_MEM  = 2'd2;

   state_t state_q;
   state_t state_d;

   logic [3:0] opcode;
   logic [1:0] src;
   logic [1:0] dest;

   assign opcode = bus.instruction[ws-1 -: 4];
   assign src    = bus.instruction[ws-5 -: 2];
   assign dest   = bus.instruction[ws-7 -: 2];

   logic       load_dest;
   logic [3:0] load_r;
   logic       load_pc;
   logic       inc_pc;
   logic [2:0] sel_bus_1;
   logic [1:0] sel_bus_2;
   logic       load_ir;
   logic       load_add_r;
   logic       load_reg_y;
   logic       load_reg_z;
   logic       write;
   logic       halted;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_dest  = 1'b0;
      load_pc    = 1'b0;
      inc_pc     = 1'b0;
      sel_bus_1  = 3'd0;
      sel_bus_2  = 2'd0;
      load_ir    = 1'b0;
      load_add_r = 1'b0;
      load_reg_y = 1'b0;
      load_reg_z = 1'b0;
      write      = 1'b0;
      halted     = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_FET1;

         S_FET1: begin
            sel_bus_1  = SEL1_PC;
            sel_bus_2  = SEL2_BUS1;
            load_add_r = 1'b1;
            state_d    = S_FET2;
         end

         S_FET2: begin
            sel_bus_2 = SEL2_MEM;
            load_ir   = 1'b1;
            inc_pc    = 1'b1;
            state_d   = S_DEC;
         end

         S_DEC: begin
            case (opcode)
               OP_NOP: state_d = S_FET1;

               OP_ADD, OP_SUB, OP_AND: begin
                  sel_bus_1  = {1'b0, src};
                  sel_bus_2  = SEL2_BUS1;
                  load_reg_y = 1'b1;
                  state_d    = S_EX1;
               end

               OP_NOT: begin
                  sel_bus_1  = {1'b0, src};
                  sel_bus_2  = SEL2_ALU;
                  load_reg_z = 1'b1;
                  load_dest  = 1'b1;
                  state_d    = S_FET1;
               end

               // Two-byte instructions: point the address register at the operand byte.
               OP_RD, OP_WR, OP_BR: begin
                  sel_bus_1  = SEL1_PC;
                  sel_bus_2  = SEL2_BUS1;
                  load_add_r = 1'b1;
                  if (opcode == OP_RD) begin
                     state_d = S_RD1;
                  end else if (opcode == OP_WR) begin
                     state_d = S_WR1;
                  end else begin
                     state_d = S_BR1;
                  end
               end

               OP_BRZ: begin
                  if (bus.zero) begin
                     sel_bus_1  = SEL1_PC;
                     sel_bus_2  = SEL2_BUS1;
                     load_add_r = 1'b1;
                     state_d    = S_BR1;
                  end else begin
                     inc_pc  = 1'b1;
                     state_d = S_FET1;
                  end
               end

               default: state_d = S_HALT;
            endcase
         end

         S_EX1: begin
            sel_bus_1  = {1'b0, dest};
            sel_bus_2  = SEL2_ALU;
            load_reg_z = 1'b1;
            load_dest  = 1'b1;
            state_d    = S_FET1;
         end

         S_RD1, S_WR1: begin
            sel_bus_2  = SEL2_MEM;
            load_add_r = 1'b1;
            inc_pc     = 1'b1;
            state_d    = (state_q == S_RD1) ? S_RD2 : S_WR2;
         end

         S_RD2: begin
            sel_bus_2 = SEL2_MEM;
            load_dest = 1'b1;
            state_d   = S_FET1;
         end

         S_WR2: begin
            sel_bus_1 = {1'b0, src};
            write     = 1'b1;
            state_d   = S_FET1;
         end

         S_BR1: begin
            sel_bus_2  = SEL2_MEM;
            load_add_r = 1'b1;
            state_d    = S_BR2;
         end

         S_BR2: begin
            sel_bus_2 = SEL2_MEM;
            load_pc   = 1'b1;
            state_d   = S_FET1;
         end

         S_HALT: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end

         // Unused encodings are treated like an illegal opcode.
         default: state_d = S_HALT;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dest
         assign load_r[gi] = load_dest && (dest == 2'(gi));
      end
   endgenerate

   assign bus.load_r0       = load_r[0];
   assign bus.load_r1       = load_r[1];
   assign bus.load_r2       = load_r[2];
   assign bus.load_r3       = load_r[3];
   assign bus.load_pc       = load_pc;
   assign bus.inc_pc        = inc_pc;
   assign bus.sel_bus_1_mux = sel_bus_1;
   assign bus.sel_bus_2_mux = sel_bus_2;
   assign bus.load_ir       = load_ir;
   assign bus.load_add_r    = load_add_r;
   assign bus.load_reg_y    = load_reg_y;
   assign bus.load_reg_z    = load_reg_z;
   assign bus.write         = write;
   assign bus.halted        = halted;

   a_one_dest_load: assert property (@(posedge clk) disable iff (!rst) $onehot0(load_r));
   a_pc_exclusive:  assert property (@(posedge clk) disable iff (!rst) !(load_pc && inc_pc));
   a_write_no_load: assert property (@(posedge clk) disable iff (!rst) !(write && (|load_r)));
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: stimulus pushes the hand-computed strobe vector for each
// cycle into a queue, a monitor pops and compares it on the falling edge (or on demand).
module tb_control_unit;
   logic clk;
   logic rst;

   control_unit_if #(.WS(8)) bus ();

   control_unit #(.ws(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {halted, write, load_reg_z, load_reg_y, load_add_r, load_ir, sel2[1:0], sel1[2:0], inc_pc, load_pc, load_r[3:0]}
   logic [16:0] outs;
   assign outs = {bus.halted, bus.write, bus.load_reg_z, bus.load_reg_y, bus.load_add_r,
                  bus.load_ir, bus.sel_bus_2_mux, bus.sel_bus_1_mux, bus.inc_pc, bus.load_pc,
                  bus.load_r3, bus.load_r2, bus.load_r1, bus.load_r0};

   function automatic logic [16:0] v(input logic h, input logic w, input logic z, input logic y,
                                     input logic ar, input logic ir, input logic [1:0] s2,
                                     input logic [2:0] s1, input logic inc, input logic pc,
                                     input logic [3:0] lr);
      return {h, w, z, y, ar, ir, s2, s1, inc, pc, lr};
   endfunction

   logic [16:0] exp_q[$];
   string       tag_q[$];
   int          total = 0;
   int          bad   = 0;
   event        sample_ev;

   logic [16:0] e_zero, e_fet1, e_fet2, e_halt;

   task automatic cyc(input logic [16:0] e, input string nm);
      exp_q.push_back(e);
      tag_q.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [7:0] ir, input string nm);
      bus.instruction = ir;
      cyc(e_fet1, {nm, "/fet1"});
      cyc(e_fet2, {nm, "/fet2"});
   endtask

   // Monitor: every falling edge (or an explicit mid-cycle sample) checks one expectation.
   initial begin
      logic [16:0] e;
      string       nm;
      forever begin
         @(negedge clk or sample_ev);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = tag_q.pop_front();
            total++;
            if (outs !== e) begin
               bad++;
               $display("FAIL %s: got %h want %h", nm, outs, e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      e_zero = '0;
      e_fet1 = v(0, 0, 0, 0, 1, 0, 2'd1, 3'd4, 0, 0, 4'b0000);
      e_fet2 = v(0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 1, 0, 4'b0000);
      e_halt = v(1, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 4'b0000);

      rst             = 1'b0;
      bus.instruction = 8'h00;
      bus.zero        = 1'b0;
      @(posedge clk);
      #1;
      cyc(e_zero, "rst_hold0");
      cyc(e_zero, "rst_hold1");
      rst = 1'b1;
      cyc(e_zero, "idle");

      fetch(8'h00, "nop");
      cyc(e_zero, "nop/dec");

      fetch(8'h16, "add");
      cyc(v(0, 0, 0, 1, 0, 0, 2'd1, 3'd1, 0, 0, 4'b0000), "add/dec");
      cyc(v(0, 0, 1, 0, 0, 0, 2'd0, 3'd2, 0, 0, 4'b0100), "add/ex1");

      fetch(8'h2B, "sub");
      bus.zero = 1'b1;
      cyc(v(0, 0, 0, 1, 0, 0, 2'd1, 3'd2, 0, 0, 4'b0000), "sub/dec");
      bus.zero = 1'b0;
      cyc(v(0, 0, 1, 0, 0, 0, 2'd0, 3'd3, 0, 0, 4'b1000), "sub/ex1");

      fetch(8'h35, "and");
      cyc(v(0, 0, 0, 1, 0, 0, 2'd1, 3'd1, 0, 0, 4'b0000), "and/dec");
      cyc(v(0, 0, 1, 0, 0, 0, 2'd0, 3'd1, 0, 0, 4'b0010), "and/ex1");

      fetch(8'h4C, "not");
      cyc(v(0, 0, 1, 0, 0, 0, 2'd0, 3'd3, 0, 0, 4'b0001), "not/dec");

      fetch(8'h53, "rd");
      cyc(e_fet1, "rd/dec");
      cyc(v(0, 0, 0, 0, 1, 0, 2'd2, 3'd0, 1, 0, 4'b0000), "rd/rd1");
      cyc(v(0, 0, 0, 0, 0, 0, 2'd2, 3'd0, 0, 0, 4'b1000), "rd/rd2");

      fetch(8'h64, "wr");
      cyc(e_fet1, "wr/dec");
      cyc(v(0, 0, 0, 0, 1, 0, 2'd2, 3'd0, 1, 0, 4'b0000), "wr/wr1");
      cyc(v(0, 1, 0, 0, 0, 0, 2'd0, 3'd1, 0, 0, 4'b0000), "wr/wr2");

      fetch(8'h70, "br");
      cyc(e_fet1, "br/dec");
      cyc(v(0, 0, 0, 0, 1, 0, 2'd2, 3'd0, 0, 0, 4'b0000), "br/br1");
      cyc(v(0, 0, 0, 0, 0, 0, 2'd2, 3'd0, 0, 1, 4'b0000), "br/br2");

      bus.zero = 1'b1;
      fetch(8'h80, "brz_t");
      cyc(e_fet1, "brz_t/dec");
      bus.zero = 1'b0;
      cyc(v(0, 0, 0, 0, 1, 0, 2'd2, 3'd0, 0, 0, 4'b0000), "brz_t/br1");
      cyc(v(0, 0, 0, 0, 0, 0, 2'd2, 3'd0, 0, 1, 4'b0000), "brz_t/br2");

      bus.zero = 1'b1;
      fetch(8'h80, "brz_n");
      bus.zero = 1'b0;
      cyc(v(0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 0, 4'b0000), "brz_n/dec");
      bus.zero = 1'b1;

      // Reset asserted in the middle of an EX1 cycle must clear every strobe at once.
      fetch(8'h16, "add_rst");
      cyc(v(0, 0, 0, 1, 0, 0, 2'd1, 3'd1, 0, 0, 4'b0000), "add_rst/dec");
      #1;
      rst = 1'b0;
      #1;
      exp_q.push_back(e_zero);
      tag_q.push_back("add_rst/async");
      ->sample_ev;
      @(posedge clk);
      #1;
      cyc(e_zero, "add_rst/held");
      rst = 1'b1;
      cyc(e_zero, "add_rst/idle");

      fetch(8'hF0, "ill");
      cyc(e_zero, "ill/dec");
      for (int i = 0; i < 20; i++) begin
         bus.instruction = 8'(i * 13);
         bus.zero        = i[0];
         cyc(e_halt, $sformatf("ill/halt%0d", i));
      end
      rst = 1'b0;
      cyc(e_zero, "ill/rst");
      rst = 1'b1;
      cyc(e_zero, "ill/idle");
      fetch(8'h00, "post");
      cyc(e_zero, "post/dec");

      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
